// File: rtl/duc_polyphase_sched.sv
// Polyphase MAC scheduler for the 4x interpolating DUC FIR (4 phases x 10 taps).
// It keeps the sample history and double-buffered coefficients, and issues 40 MAC ops per accepted sample.
module duc_polyphase_sched #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clkin,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          coef_wr_en,
    input  logic [15:0]   coef_wr_addr,
    input  logic [CW-1:0] coef_wr_data,
    input  logic          coef_commit,
    output logic          mac_valid,
    output logic [DW-1:0] mac_a,
    output logic [CW-1:0] mac_b,
    output logic          mac_first,
    output logic          mac_last,
    output logic [1:0]    mac_phase,
    output logic          bank_sel,
    output logic          commit_pending
);

    localparam int unsigned NTAPS = 10;
    localparam int unsigned NCOEF = 40;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    tap;
    logic [3:0]    tap_nxt;
    logic [1:0]    phase;
    logic [1:0]    phase_nxt;
    logic          last_op;
    logic          accept;
    logic          swap_now;
    logic          coef_wr_ok;
    logic [5:0]    coef_idx;

    logic [DW-1:0] hist [NTAPS];
    logic [CW-1:0] bank [2][NCOEF];

    // Coefficient index 4*j + p is just the tap and phase counters concatenated.
    assign coef_idx   = {tap, phase};
    assign coef_wr_ok = coef_wr_en && (coef_wr_addr < 16'(NCOEF));

    always_comb begin
        state_nxt = state;
        tap_nxt   = tap;
        phase_nxt = phase;
        mac_valid = 1'b0;
        mac_first = 1'b0;
        mac_last  = 1'b0;
        mac_phase = '0;
        mac_a     = '0;
        mac_b     = '0;
        last_op   = (state == RUN) && (phase == 2'd3) && (tap == 4'd9);
        din_ready = (state == IDLE) || last_op;
        accept    = din_valid && din_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    tap_nxt   = '0;
                    phase_nxt = '0;
                end
            end
            RUN: begin
                mac_valid = 1'b1;
                mac_first = (tap == 4'd0);
                mac_last  = (tap == 4'd9);
                mac_phase = phase;
                mac_a     = hist[tap];
                mac_b     = bank[bank_sel][coef_idx];
                if (tap == 4'd9) begin
                    tap_nxt = '0;
                    if (phase == 2'd3) begin
                        phase_nxt = '0;
                        state_nxt = accept ? RUN : IDLE;
                    end else begin
                        phase_nxt = phase + 2'd1;
                    end
                end else begin
                    tap_nxt = tap + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tap   <= '0;
            phase <= '0;
        end else begin
            state <= state_nxt;
            tap   <= tap_nxt;
            phase <= phase_nxt;
        end
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                hist[i] <= '0;
            end
        end else if (accept) begin
            hist[0] <= din;
            for (int unsigned i = 1; i < NTAPS; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // Writes always target the pre-edge shadow bank; if a swap lands on the
    // same edge, the freshly written value becomes active with it.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < NCOEF; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (coef_wr_ok) begin
            bank[~bank_sel][coef_wr_addr[5:0]] <= coef_wr_data;
        end
    end

    // Swaps only between samples: any IDLE edge or the edge closing op (3,9).
    assign swap_now = (commit_pending || coef_commit) && ((state == IDLE) || last_op);

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            bank_sel       <= 1'b0;
            commit_pending <= 1'b0;
        end else if (swap_now) begin
            bank_sel       <= ~bank_sel;
            commit_pending <= 1'b0;
        end else if (coef_commit) begin
            commit_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_duc_polyphase_sched.sv
// Directed bench for duc_polyphase_sched: impulse, back-to-back, commit timing,
// address bounds, mid-run reset and ignored din while busy.
module tb_duc_polyphase_sched;

    logic        clkin;
    logic        reset;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        coef_wr_en;
    logic [15:0] coef_wr_addr;
    logic [15:0] coef_wr_data;
    logic        coef_commit;
    logic        mac_valid;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_first;
    logic        mac_last;
    logic [1:0]  mac_phase;
    logic        bank_sel;
    logic        commit_pending;

    duc_polyphase_sched #(.DW(16), .CW(16)) dut (
        .clkin(clkin), .reset(reset),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data), .coef_commit(coef_commit),
        .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
        .mac_first(mac_first), .mac_last(mac_last), .mac_phase(mac_phase),
        .bank_sel(bank_sel), .commit_pending(commit_pending)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_hist [10];
    logic [15:0] m_bank [2][40];
    logic        m_sel;
    logic        m_pend;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    function automatic logic [63:0] obs_op();
        return {27'd0, mac_valid, mac_first, mac_last, mac_phase, mac_a, mac_b};
    endfunction

    function automatic logic [63:0] obs_st();
        return {61'd0, din_ready, commit_pending, bank_sel};
    endfunction

    function automatic logic [63:0] exp_op(input int k);
        int j;
        int p;
        j = k % 10;
        p = k / 10;
        return {27'd0, 1'b1, (j == 0), (j == 9), 2'(p), m_hist[j], m_bank[m_sel][4*j+p]};
    endfunction

    task automatic zero_model();
        for (int i = 0; i < 10; i++) m_hist[i] = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 40; i++) m_bank[b][i] = '0;
        m_sel  = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic shift_model(input logic [15:0] x);
        for (int i = 9; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
    endtask

    task automatic swap_model();
        m_sel  = ~m_sel;
        m_pend = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = addr;
        coef_wr_data = data;
        tick();
        coef_wr_en = 1'b0;
        if (addr < 16'd40) m_bank[~m_sel][addr[5:0]] = data;
    endtask

    task automatic wr_commit(input logic [15:0] addr, input logic [15:0] data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = addr;
        coef_wr_data = data;
        coef_commit  = 1'b1;
        tick();
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        m_bank[~m_sel][addr[5:0]] = data;
        swap_model();
        check_eq("wr_commit_st", obs_st(), {61'd0, 1'b1, m_pend, m_sel});
    endtask

    task automatic commit_idle();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        swap_model();
        check_eq("commit_idle_st", obs_st(), {61'd0, 1'b1, m_pend, m_sel});
    endtask

    task automatic offer(input logic [15:0] x);
        check_eq("idle_op", obs_op(), 64'd0);
        check_eq("idle_st", obs_st(), {61'd0, 1'b1, m_pend, m_sel});
        din       = x;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        shift_model(x);
    endtask

    task automatic check_ops(input string tag, input int n_ops, input bit nxt,
                             input logic [15:0] nxt_x, input int commit_k,
                             input int wr_k, input bit noise);
        for (int k = 0; k < n_ops; k++) begin
            check_eq($sformatf("%s op%0d", tag, k), obs_op(), exp_op(k));
            check_eq($sformatf("%s st%0d", tag, k), obs_st(), {61'd0, (k == 39), m_pend, m_sel});
            din_valid    = (noise && k >= 4 && k <= 38) || (nxt && k == 39);
            din          = (nxt && k == 39) ? nxt_x : 16'h5555;
            coef_commit  = (k == commit_k);
            coef_wr_en   = (k == wr_k);
            coef_wr_addr = 16'd0;
            coef_wr_data = 16'h7777;
            if (k == wr_k) m_bank[~m_sel][0] = 16'h7777;
            tick();
            coef_commit = 1'b0;
            coef_wr_en  = 1'b0;
            if (k == commit_k) m_pend = 1'b1;
            if (k == 39) begin
                if (m_pend) swap_model();
                if (nxt) shift_model(nxt_x);
            end
        end
        din_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        din          = '0;
        din_valid    = 1'b0;
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        coef_commit  = 1'b0;
        zero_model();
        tick();
        tick();
        check_eq("reset_op", obs_op(), 64'd0);
        check_eq("reset_st", obs_st(), 64'd4);
        #2 reset = 1'b1;
        tick();

        // Impulse response with h[k] = k+1
        for (int k = 0; k < 40; k++) wr(16'(k), 16'(k + 1));
        commit_idle();
        check_eq("impulse_bank_sel", {63'd0, bank_sel}, 64'd1);
        offer(16'd1);
        check_ops("imp1", 40, 1'b0, 16'd0, -1, -1, 1'b0);
        offer(16'd0);
        check_ops("imp0", 40, 1'b0, 16'd0, -1, -1, 1'b0);

        // New shadow set plus out-of-range writes that must be dropped
        for (int k = 0; k < 40; k++) wr(16'(k), 16'(2 * k + 3));
        wr(16'd40, 16'hDEAD);
        wr(16'hFFFF, 16'hBEEF);

        // Back-to-back samples with a mid-run commit, then a busy-time write and din noise
        offer(16'd100);
        check_ops("b2b0", 40, 1'b1, 16'd200, 9, -1, 1'b0);
        check_ops("b2b1", 40, 1'b0, 16'd0, -1, 5, 1'b1);

        // Write and swap on the same edge
        wr_commit(16'd1, 16'h0ABC);
        offer(16'd3);
        check_ops("wsame", 40, 1'b0, 16'd0, -1, -1, 1'b0);

        // Reset in cycle 20 of a run with a commit pending
        offer(16'd5);
        check_ops("prerst", 19, 1'b0, 16'd0, 3, -1, 1'b0);
        check_eq("prerst_st", obs_st(), {61'd0, 1'b0, 1'b1, 1'b1});
        reset = 1'b0;
        #1;
        zero_model();
        check_eq("rst_mid_op", obs_op(), 64'd0);
        check_eq("rst_mid_st", obs_st(), 64'd4);
        din       = 16'd9;
        din_valid = 1'b1;
        tick();
        tick();
        check_eq("rst_hold_op", obs_op(), 64'd0);
        din_valid = 1'b0;
        #2 reset = 1'b1;
        tick();
        offer(16'd7);
        check_ops("postrst", 40, 1'b0, 16'd0, -1, -1, 1'b0);
        check_eq("final_op", obs_op(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
